axis_frame_tx: RTL and testbench
================================

// Module: axis_frame_tx
// PURPOSE
//  AXI-Stream frame transmitter: on a start command, reads frame_len words from a
//  sample RAM (1-cycle read latency) starting at base_addr and emits them as one
//  frame on m_data/m_valid/m_last, honouring m_ready backpressure.
//  Feeds the slave (s_*) side of the 4096-deep AXI FIFO; sits between sample RAM and FIFO.
// PARAMETERS
//  DataWidth  16                 stream / RAM word width
//  Depth      4096               sample RAM depth (words)
//  AddrWidth  $clog2(Depth)      RAM address width
//  LenWidth   $clog2(Depth)+1    frame_len width (1..Depth words)
// PORTS
//  clk          in   1          single clock, all logic on posedge
//  rst          in   1          synchronous reset, active-low (0 = reset)
//  start        in   1          start pulse; accepted only when busy=0
//  base_addr    in   AddrWidth  first RAM address, sampled with start
//  frame_len    in   LenWidth   words in frame, sampled with start
//  busy         out  1          frame in progress
//  done         out  1          1-cycle pulse, frame complete
//  mem_rd_en    out  1          RAM read strobe
//  mem_addr     out  AddrWidth  RAM read address
//  mem_rd_data  in   DataWidth  RAM data, valid 1 cycle after mem_rd_en
//  m_data       out  DataWidth  stream data
//  m_valid      out  1          stream valid
//  m_ready      in   1          stream ready (from FIFO s_ready)
//  m_last       out  1          final beat of frame
// BEHAVIOUR
//  - Reset (rst=0 at posedge): all outputs 0; FSM=IDLE; skid buffer empty; in-flight read discarded.
//  - FSM: IDLE -start&&frame_len!=0-> RUN; RUN -last data beat handshaked-> (CSUM if
//    TX_CHECKSUM_EN) -> DONE; DONE -> IDLE (done=1 for this one cycle).
//    IDLE -start&&frame_len==0-> DONE (no beats, no reads).
//  - start while busy: ignored, latched base/len unchanged.
//  - Reads: addr = base_addr + n, n=0..frame_len-1, wraps mod Depth (AddrWidth arithmetic).
//    Issue read only if (buffer occupancy + reads in flight) < 2; never reads past frame end.
//  - 2-entry skid buffer holds RAM data; m_valid = buffer non-empty.
//  - Latency: start sampled at edge T -> mem_rd_en at T+1 -> m_valid at T+2.
//    m_ready held 1 => one beat per cycle, no bubbles after first beat.
//  - AXI rule: once m_valid=1, m_data/m_last stable until m_valid&&m_ready; m_valid never
//    drops without handshake (except reset).
//  - m_last=1 exactly on beat frame_len (or checksum beat when enabled); never otherwise.
//  - Beat counter LenWidth bits; frame_len=Depth legal (full RAM, wraps to base).
//  - busy=1 from edge after accepted start until edge after done pulse.
//  - Reset mid-frame: m_valid/m_last to 0 next edge, no done pulse, partial frame abandoned.
// CONFIGURATION
//  TX_CHECKSUM_EN defined: one extra beat appended after data = sum of all data words
//   mod 2^DataWidth; m_last moves to this beat; frame is frame_len+1 beats;
//   frame_len==0 still sends nothing.
//  Not defined: frame is exactly frame_len beats, no adder/CSUM state synthesised.
// STRUCTURE
//  Package axis_tx_pkg: FSM state encoding (IDLE, RUN, CSUM, DONE), DataWidth/Depth defaults,
//   SKID_DEPTH=2 constant.
//  Sub-module axis_skid_buf: 2-entry register buffer (push/pop, occupancy out) holding m_data/m_last.
//  Top: FSM, address/beat counters, in-flight tracker, optional checksum accumulator.
// TESTING
//  1 base=0,len=4, RAM[i]=i+1, m_ready=1 -> beats 1,2,3,4 on consecutive cycles,
//    first m_valid 2 cycles after start, m_last on 4, done 1 cycle after.
//  2 len=8, m_ready toggles 1,0,1,0... -> 8 beats in order, data stable while stalled,
//    never >2 reads outstanding beyond buffer space.
//  3 base=4094,len=4 -> mem_addr 4094,4095,0,1; data order matches.
//  4 len=0 start -> no mem_rd_en, no m_valid, done pulse; start during busy -> ignored.
//  5 rst=0 in middle of len=16 frame, m_ready=0 -> m_valid=0 next edge, no done;
//    new start after reset sends full fresh frame.
//  6 TX_CHECKSUM_EN, RAM=0x8000,0x8001,0x0002, len=3 -> beats 8000,8001,0002,0003,
//    m_last only on 0x0003.

Source files
------------

// File: rtl/axis_tx_pkg.sv
// Shared types and defaults for the AXI-Stream frame transmitter.
package axis_tx_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int DEPTH      = 4096;
  localparam int SKID_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_CSUM = 2'd2,
    ST_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register FIFO that holds RAM words (plus last flag) in front of the stream port.
module axis_skid_buf
  import axis_tx_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic                 push_last_i,
  input  logic                 pop_i,
  output logic [DataWidth-1:0] data_o,
  output logic                 last_o,
  output logic                 valid_o,
  output logic [1:0]           occ_o
);

  typedef struct packed {
    logic                 last;
    logic [DataWidth-1:0] data;
  } entry_t;

  entry_t     head_q, head_d, tail_q, tail_d, in_e;
  logic [1:0] occ_q, occ_d;
  logic       pop_eff, push_eff;

  assign pop_eff  = pop_i && (occ_q != 2'd0);
  assign push_eff = push_i && ((occ_q != 2'(SKID_DEPTH)) || pop_eff);
  assign in_e     = '{last: push_last_i, data: push_data_i};

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    unique case ({push_eff, pop_eff})
      2'b10: begin
        if (occ_q == 2'd0) head_d = in_e;
        else               tail_d = in_e;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'(SKID_DEPTH)) begin
          head_d = tail_q;
          tail_d = in_e;
        end else begin
          head_d = in_e;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the storage entries are reset as well, because m_data must read 0 straight after reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign data_o  = head_q.data;
  assign last_o  = head_q.last;
  assign valid_o = (occ_q != 2'd0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/axis_frame_tx.sv
// Reads frame_len words from sample RAM and streams them as one AXI-Stream frame.
// Define TX_CHECKSUM_EN to append a sum-of-words beat that carries m_last.
module axis_frame_tx
  import axis_tx_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int Depth     = DEPTH,
  parameter int AddrWidth = $clog2(Depth),
  parameter int LenWidth  = $clog2(Depth) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [AddrWidth-1:0] base_addr,
  input  logic [LenWidth-1:0]  frame_len,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [AddrWidth-1:0] mem_addr,
  input  logic [DataWidth-1:0] mem_rd_data,
  output logic [DataWidth-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);

  tx_state_e            state_q, state_d;
  logic                 busy_q, busy_d, done_q, done_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [LenWidth-1:0]  reads_left_q, reads_left_d;
  logic [LenWidth-1:0]  beats_left_q, beats_left_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_last_q, inflight_last_d;
`ifdef TX_CHECKSUM_EN
  logic [DataWidth-1:0] csum_q, csum_d;
`endif

  logic                 pop, push, push_last, rd_en, last_beat_hs;
  logic [DataWidth-1:0] push_data;
  logic [1:0]           occ;
  logic [2:0]           credit;

  assign pop          = m_valid && m_ready;
  assign last_beat_hs = (state_q == ST_RUN) && pop && (beats_left_q == LenWidth'(1));

  // Space is counted after this cycle's pop so a steady m_ready keeps one beat per cycle.
  assign credit = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_en  = (state_q == ST_RUN) && (reads_left_q != '0) && (credit < 3'(SKID_DEPTH));

  always_comb begin
    push      = inflight_q;
    push_data = mem_rd_data;
    push_last = inflight_last_q;
`ifdef TX_CHECKSUM_EN
    push_last = 1'b0;
    if (last_beat_hs) begin
      push      = 1'b1;
      push_data = csum_q;
      push_last = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    reads_left_d    = reads_left_q;
    beats_left_d    = beats_left_q;
    inflight_d      = rd_en;
    inflight_last_d = rd_en && (reads_left_q == LenWidth'(1));
`ifdef TX_CHECKSUM_EN
    csum_d = inflight_q ? csum_q + mem_rd_data : csum_q;
`endif

    if (rd_en) begin
      addr_d       = addr_q + AddrWidth'(1);
      reads_left_d = reads_left_q - LenWidth'(1);
    end
    if (pop && (state_q == ST_RUN)) beats_left_d = beats_left_q - LenWidth'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d       = base_addr;
          reads_left_d = frame_len;
          beats_left_d = frame_len;
          state_d      = (frame_len == '0) ? ST_DONE : ST_RUN;
`ifdef TX_CHECKSUM_EN
          csum_d = '0;
`endif
        end
      end
      ST_RUN: begin
`ifdef TX_CHECKSUM_EN
        if (last_beat_hs) state_d = ST_CSUM;
`else
        if (last_beat_hs) state_d = ST_DONE;
`endif
      end
`ifdef TX_CHECKSUM_EN
      ST_CSUM: if (pop) state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      addr_q          <= '0;
      reads_left_q    <= '0;
      beats_left_q    <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
`ifdef TX_CHECKSUM_EN
      csum_q          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      addr_q          <= addr_d;
      reads_left_q    <= reads_left_d;
      beats_left_q    <= beats_left_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
`ifdef TX_CHECKSUM_EN
      csum_q          <= csum_d;
`endif
    end
  end

  axis_skid_buf #(
    .DataWidth(DataWidth)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(push_data),
    .push_last_i(push_last),
    .pop_i      (pop),
    .data_o     (m_data),
    .last_o     (m_last),
    .valid_o    (m_valid),
    .occ_o      (occ)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_rd_en = rd_en;
  assign mem_addr  = addr_q;

endmodule

// File: tb/tb_axis_frame_tx.sv
// Directed bench for axis_frame_tx: RAM model, handshake monitor, one task per scenario.
module tb_axis_frame_tx;

  localparam int DW = 16;
  localparam int AW = 12;
  localparam int LW = 13;
`ifdef TX_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic          clk, rst, start, busy, done, mem_rd_en, m_valid, m_ready, m_last;
  logic [AW-1:0] base_addr, mem_addr;
  logic [LW-1:0] frame_len;
  logic [DW-1:0] mem_rd_data, m_data;
  logic [DW-1:0] ram [0:4095];

  int n_pass  = 0;
  int n_total = 0;

  axis_frame_tx dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .frame_len  (frame_len),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rd_data(mem_rd_data),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

  // Monitor: records handshakes, reads and done pulses; flags AXI stability and overfetch errors.
  int            cyc = 0;
  logic [DW-1:0] cap_data [$];
  logic          cap_last [$];
  int            cap_cyc  [$];
  logic [AW-1:0] rd_addrs [$];
  int            done_cnt = 0, done_cyc = 0, proto_err = 0, outstanding = 0;
  logic          prev_stall = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      outstanding <= 0;
      prev_stall  <= 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        cap_data.push_back(m_data);
        cap_last.push_back(m_last);
        cap_cyc.push_back(cyc);
      end
      if (mem_rd_en) rd_addrs.push_back(mem_addr);
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      proto_err <= proto_err
        + int'(prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last))
        + int'(outstanding + int'(mem_rd_en) - int'(m_valid && m_ready) > 2);
      outstanding <= outstanding + int'(mem_rd_en) - int'(m_valid && m_ready);
      prev_stall  <= m_valid && !m_ready;
      prev_data   <= m_data;
      prev_last   <= m_last;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_done(input int d0, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic launch(input logic [AW-1:0] base, input logic [LW-1:0] len, output int n);
    @(posedge clk); #1;
    n = cyc;
    start = 1'b1; base_addr = base; frame_len = len;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; base_addr = '0; frame_len = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({m_valid, m_last, busy, done, mem_rd_en} !== 5'b0)
      $display("FAIL reset_ctrl: got %b want 00000", {m_valid, m_last, busy, done, mem_rd_en});
    else n_pass++;
    n_total++;
    if ({m_data, mem_addr} !== '0) $display("FAIL reset_data: m_data=%h mem_addr=%h want 0", m_data, mem_addr);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    int s0, d0, n, nb;
    bit ok;
    for (int i = 0; i < 4; i++) ram[i] = 16'(i + 1);
    s0 = cap_data.size(); d0 = done_cnt; m_ready = 1'b1;
    launch(12'd0, 13'd4, n);
    n_total++;
    if (busy !== 1'b1) $display("FAIL basic_busy_start: got %b want 1", busy); else n_pass++;
    wait_done(d0, 60, ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL basic_done_seen: got %b want 1", ok); else n_pass++;
    n_total++;
    if (done_cyc !== n + 7 + CS) $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, n + 7 + CS);
    else n_pass++;
    n_total++;
    if (busy !== 1'b1) $display("FAIL basic_busy_in_done: got %b want 1", busy); else n_pass++;
    nb = cap_data.size() - s0;
    n_total++;
    if (nb !== 4 + CS) $display("FAIL basic_beats: got %0d want %0d", nb, 4 + CS); else n_pass++;
    for (int i = 0; i < nb && i < 4 + CS; i++) begin
      n_total++;
      if (cap_cyc[s0 + i] !== n + 3 + i || cap_last[s0 + i] !== (i == 3 + CS))
        $display("FAIL basic_beat%0d_timing: cyc=%0d last=%b want cyc=%0d last=%b",
                 i, cap_cyc[s0 + i], cap_last[s0 + i], n + 3 + i, (i == 3 + CS));
      else n_pass++;
      if (i < 4) begin
        n_total++;
        if (cap_data[s0 + i] !== 16'(i + 1))
          $display("FAIL basic_beat%0d_data: got %h want %h", i, cap_data[s0 + i], 16'(i + 1));
        else n_pass++;
      end
    end
    @(posedge clk); #1;
    n_total++;
    if ({busy, done} !== 2'b00) $display("FAIL basic_idle_after: busy,done=%b want 00", {busy, done});
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int s0, d0, e0, n, nb;
    bit ok;
    for (int i = 0; i < 8; i++) ram[16 + i] = 16'(16'hA000 + i);
    s0 = cap_data.size(); d0 = done_cnt; e0 = proto_err; m_ready = 1'b1;
    @(posedge clk); #1;
    n = cyc;
    start = 1'b1; base_addr = 12'd16; frame_len = 13'd8;
    ok = 1'b0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      m_ready = ~m_ready;
      if (done_cnt > d0) begin
        ok = 1'b1;
        break;
      end
    end
    m_ready = 1'b1;
    n_total++;
    if (ok !== 1'b1) $display("FAIL bp_done_seen: got %b want 1 (start at cyc %0d)", ok, n); else n_pass++;
    nb = cap_data.size() - s0;
    n_total++;
    if (nb !== 8 + CS) $display("FAIL bp_beats: got %0d want %0d", nb, 8 + CS); else n_pass++;
    for (int i = 0; i < nb && i < 8 + CS; i++) begin
      n_total++;
      if (cap_last[s0 + i] !== (i == 7 + CS))
        $display("FAIL bp_beat%0d_last: got %b want %b", i, cap_last[s0 + i], (i == 7 + CS));
      else n_pass++;
      if (i < 8) begin
        n_total++;
        if (cap_data[s0 + i] !== 16'(16'hA000 + i))
          $display("FAIL bp_beat%0d_data: got %h want %h", i, cap_data[s0 + i], 16'(16'hA000 + i));
        else n_pass++;
      end
    end
    n_total++;
    if (proto_err - e0 !== 0) $display("FAIL bp_protocol: got %0d errors want 0", proto_err - e0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [4] = '{12'd4094, 12'd4095, 12'd0, 12'd1};
    logic [DW-1:0] exp_d [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    int s0, d0, r0, n, nb, nr;
    bit ok;
    for (int i = 0; i < 4; i++) ram[exp_a[i]] = exp_d[i];
    s0 = cap_data.size(); d0 = done_cnt; r0 = rd_addrs.size(); m_ready = 1'b1;
    launch(12'd4094, 13'd4, n);
    wait_done(d0, 60, ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL wrap_done_seen: got %b want 1", ok); else n_pass++;
    nr = rd_addrs.size() - r0;
    n_total++;
    if (nr !== 4) $display("FAIL wrap_reads: got %0d want 4", nr); else n_pass++;
    for (int i = 0; i < nr && i < 4; i++) begin
      n_total++;
      if (rd_addrs[r0 + i] !== exp_a[i])
        $display("FAIL wrap_addr%0d: got %0d want %0d", i, rd_addrs[r0 + i], exp_a[i]);
      else n_pass++;
    end
    nb = cap_data.size() - s0;
    for (int i = 0; i < nb && i < 4; i++) begin
      n_total++;
      if (cap_data[s0 + i] !== exp_d[i])
        $display("FAIL wrap_data%0d: got %h want %h", i, cap_data[s0 + i], exp_d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_zero_len_and_ignore();
    int s0, d0, r0, n, nb;
    bit ok;
    s0 = cap_data.size(); d0 = done_cnt; r0 = rd_addrs.size(); m_ready = 1'b1;
    launch(12'd5, 13'd0, n);
    n_total++;
    if ({busy, done} !== 2'b11) $display("FAIL zero_done_pulse: busy,done=%b want 11", {busy, done});
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({busy, done} !== 2'b00) $display("FAIL zero_idle: busy,done=%b want 00", {busy, done});
    else n_pass++;
    repeat (4) @(posedge clk); #1;
    n_total++;
    if (rd_addrs.size() - r0 !== 0 || cap_data.size() - s0 !== 0)
      $display("FAIL zero_no_traffic: reads=%0d beats=%0d want 0 0", rd_addrs.size() - r0, cap_data.size() - s0);
    else n_pass++;
    n_total++;
    if (done_cnt - d0 !== 1) $display("FAIL zero_done_count: got %0d want 1", done_cnt - d0); else n_pass++;

    for (int i = 0; i < 4; i++) ram[i] = 16'(16'h0A01 + i);
    s0 = cap_data.size(); d0 = done_cnt;
    launch(12'd0, 13'd4, n);
    start = 1'b1; base_addr = 12'd100; frame_len = 13'd2;
    repeat (3) @(posedge clk); #1;
    start = 1'b0;
    wait_done(d0, 60, ok);
    repeat (3) @(posedge clk); #1;
    nb = cap_data.size() - s0;
    n_total++;
    if (nb !== 4 + CS) $display("FAIL ignore_beats: got %0d want %0d", nb, 4 + CS); else n_pass++;
    for (int i = 0; i < nb && i < 4; i++) begin
      n_total++;
      if (cap_data[s0 + i] !== 16'(16'h0A01 + i))
        $display("FAIL ignore_data%0d: got %h want %h", i, cap_data[s0 + i], 16'(16'h0A01 + i));
      else n_pass++;
    end
    n_total++;
    if (done_cnt - d0 !== 1) $display("FAIL ignore_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int s0, d0, n, nb;
    bit ok;
    for (int i = 0; i < 16; i++) ram[200 + i] = 16'(16'h5000 + i);
    d0 = done_cnt; m_ready = 1'b0;
    launch(12'd200, 13'd16, n);
    repeat (5) @(posedge clk); #1;
    n_total++;
    if (m_valid !== 1'b1) $display("FAIL midrst_valid_before: got %b want 1", m_valid); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    n_total++;
    if ({m_valid, m_last, busy, done, mem_rd_en} !== 5'b0)
      $display("FAIL midrst_outputs: got %b want 00000", {m_valid, m_last, busy, done, mem_rd_en});
    else n_pass++;
    repeat (4) @(posedge clk); #1;
    n_total++;
    if (done_cnt - d0 !== 0) $display("FAIL midrst_no_done: got %0d want 0", done_cnt - d0); else n_pass++;

    s0 = cap_data.size(); d0 = done_cnt; m_ready = 1'b1;
    launch(12'd200, 13'd16, n);
    wait_done(d0, 80, ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL midrst_fresh_done: got %b want 1", ok); else n_pass++;
    nb = cap_data.size() - s0;
    n_total++;
    if (nb !== 16 + CS) $display("FAIL midrst_fresh_beats: got %0d want %0d", nb, 16 + CS); else n_pass++;
    for (int i = 0; i < nb && i < 16; i++) begin
      n_total++;
      if (cap_data[s0 + i] !== 16'(16'h5000 + i) || cap_last[s0 + i] !== (i == 15 + CS))
        $display("FAIL midrst_fresh_beat%0d: data=%h last=%b want data=%h last=%b",
                 i, cap_data[s0 + i], cap_last[s0 + i], 16'(16'h5000 + i), (i == 15 + CS));
      else n_pass++;
    end
  endtask

`ifdef TX_CHECKSUM_EN
  task automatic test_checksum();
    logic [DW-1:0] exp_d [4] = '{16'h8000, 16'h8001, 16'h0002, 16'h0003};
    int s0, d0, n, nb;
    bit ok;
    ram[300] = 16'h8000; ram[301] = 16'h8001; ram[302] = 16'h0002;
    s0 = cap_data.size(); d0 = done_cnt; m_ready = 1'b1;
    launch(12'd300, 13'd3, n);
    wait_done(d0, 60, ok);
    nb = cap_data.size() - s0;
    n_total++;
    if (nb !== 4) $display("FAIL csum_beats: got %0d want 4", nb); else n_pass++;
    for (int i = 0; i < nb && i < 4; i++) begin
      n_total++;
      if (cap_data[s0 + i] !== exp_d[i] || cap_last[s0 + i] !== (i == 3))
        $display("FAIL csum_beat%0d: data=%h last=%b want data=%h last=%b",
                 i, cap_data[s0 + i], cap_last[s0 + i], exp_d[i], (i == 3));
      else n_pass++;
    end
  endtask
`endif

  task automatic test_protocol();
    n_total++;
    if (proto_err !== 0) $display("FAIL protocol_total: got %0d errors want 0", proto_err); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len_and_ignore();
    test_reset_mid_frame();
`ifdef TX_CHECKSUM_EN
    test_checksum();
`endif
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
